// File: rtl/id_ex_forward_stage.sv
// id_ex_forward_stage: N-port operand forwarding, load-use interlock, flush and registered ID/EX boundary
module id_ex_forward_stage #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 4,
  parameter int NUM_PORTS = 3,
  parameter int CTRL_W    = 16,
  parameter int PC_REG    = 15,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        id_valid,
  input  logic [NUM_PORTS*REG_AW-1:0] id_src_reg,
  input  logic [NUM_PORTS-1:0]        id_src_used,
  input  logic [NUM_PORTS*DATA_W-1:0] id_rf_data,
  input  logic [CTRL_W-1:0]           id_ctrl,
  input  logic [REG_AW-1:0]           id_dest_reg,
  input  logic                        id_dest_we,
  input  logic                        id_is_load,
  input  logic [REG_AW-1:0]           ex_dest_reg,
  input  logic [REG_AW-1:0]           mem_dest_reg,
  input  logic [REG_AW-1:0]           wb_dest_reg,
  input  logic                        ex_we,
  input  logic                        mem_we,
  input  logic                        wb_we,
  input  logic                        ex_is_load_in,
  input  logic [DATA_W-1:0]           ex_result,
  input  logic [DATA_W-1:0]           mem_result,
  input  logic [DATA_W-1:0]           wb_result,
  input  logic                        flush,
  output logic                        stall,
  output logic                        ex_valid,
  output logic [NUM_PORTS*DATA_W-1:0] ex_operand,
  output logic [CTRL_W-1:0]           ex_ctrl,
  output logic [REG_AW-1:0]           ex_dest,
  output logic                        ex_dest_we,
  output logic                        ex_is_load,
  output logic [CNT_W-1:0]            stall_count
);
  logic [NUM_PORTS*DATA_W-1:0] fwd;
  logic [NUM_PORTS-1:0]        hit;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [REG_AW-1:0] src;
    logic [DATA_W-1:0] rf;
    logic              act;
    assign src = id_src_reg[i*REG_AW +: REG_AW];
    assign rf  = id_rf_data[i*DATA_W +: DATA_W];
    // the PC pseudo-register always comes from the RF, never from the bypass network
    assign act = id_src_used[i] && src != REG_AW'(PC_REG);
    assign hit[i] = act && ex_we && src == ex_dest_reg;
    assign fwd[i*DATA_W +: DATA_W] =
      !act                            ? rf         :
      (hit[i] && !ex_is_load_in)      ? ex_result  :
      (mem_we && src == mem_dest_reg) ? mem_result :
      (wb_we && src == wb_dest_reg)   ? wb_result  : rf;
  end
  assign stall = reset && id_valid && ex_is_load_in && |hit && !flush;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_operand  <= '0;
      ex_ctrl     <= '0;
      ex_dest     <= '0;
      ex_dest_we  <= 1'b0;
      ex_is_load  <= 1'b0;
      stall_count <= '0;
    end else begin
      if (flush || stall) begin
        ex_valid   <= 1'b0;
        ex_ctrl    <= '0;
        ex_dest_we <= 1'b0;
        ex_is_load <= 1'b0;
      end else begin
        ex_valid   <= id_valid;
        ex_operand <= fwd;
        ex_ctrl    <= id_ctrl;
        ex_dest    <= id_dest_reg;
        ex_dest_we <= id_valid && id_dest_we;
        ex_is_load <= id_valid && id_is_load;
      end
      if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_id_ex_forward_stage.sv
// tb_id_ex_forward_stage: scoreboard-driven checks of forwarding, interlock, flush, reset and counter saturation
module tb_id_ex_forward_stage;
  logic        clk = 0, reset = 0;
  logic        id_valid, id_dest_we, id_is_load, flush;
  logic [11:0] id_src_reg;
  logic [2:0]  id_src_used;
  logic [95:0] id_rf_data;
  logic [15:0] id_ctrl;
  logic [3:0]  id_dest_reg, ex_dest_reg, mem_dest_reg, wb_dest_reg;
  logic        ex_we, mem_we, wb_we, ex_is_load_in;
  logic [31:0] ex_result, mem_result, wb_result;
  logic        stall, ex_valid, ex_dest_we, ex_is_load;
  logic [95:0] ex_operand;
  logic [15:0] ex_ctrl, stall_count;
  logic [3:0]  ex_dest;
  logic        stall2, ex_valid2, ex_dest_we2, ex_is_load2;
  logic [95:0] ex_operand2;
  logic [15:0] ex_ctrl2;
  logic [3:0]  ex_dest2;
  logic [1:0]  stall_count2;
  int pass = 0, total = 0;
  typedef struct { logic v; logic [31:0] op; int port; } exp_t;
  exp_t sb[$];
  exp_t e;
  always #5 clk = ~clk;
  id_ex_forward_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_reg(id_src_reg), .id_src_used(id_src_used),
    .id_rf_data(id_rf_data), .id_ctrl(id_ctrl), .id_dest_reg(id_dest_reg), .id_dest_we(id_dest_we),
    .id_is_load(id_is_load), .ex_dest_reg(ex_dest_reg), .mem_dest_reg(mem_dest_reg), .wb_dest_reg(wb_dest_reg),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load_in(ex_is_load_in), .ex_result(ex_result),
    .mem_result(mem_result), .wb_result(wb_result), .flush(flush), .stall(stall), .ex_valid(ex_valid),
    .ex_operand(ex_operand), .ex_ctrl(ex_ctrl), .ex_dest(ex_dest), .ex_dest_we(ex_dest_we),
    .ex_is_load(ex_is_load), .stall_count(stall_count));
  id_ex_forward_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_reg(id_src_reg), .id_src_used(id_src_used),
    .id_rf_data(id_rf_data), .id_ctrl(id_ctrl), .id_dest_reg(id_dest_reg), .id_dest_we(id_dest_we),
    .id_is_load(id_is_load), .ex_dest_reg(ex_dest_reg), .mem_dest_reg(mem_dest_reg), .wb_dest_reg(wb_dest_reg),
    .ex_we(ex_we), .mem_we(mem_we), .wb_we(wb_we), .ex_is_load_in(ex_is_load_in), .ex_result(ex_result),
    .mem_result(mem_result), .wb_result(wb_result), .flush(flush), .stall(stall2), .ex_valid(ex_valid2),
    .ex_operand(ex_operand2), .ex_ctrl(ex_ctrl2), .ex_dest(ex_dest2), .ex_dest_we(ex_dest_we2),
    .ex_is_load(ex_is_load2), .stall_count(stall_count2));
  task automatic idle();
    id_valid = 0; id_dest_we = 0; id_is_load = 0; flush = 0;
    id_src_reg = '0; id_src_used = '0; id_rf_data = '0; id_ctrl = '0; id_dest_reg = '0;
    ex_dest_reg = 0; mem_dest_reg = 0; wb_dest_reg = 0; ex_we = 0; mem_we = 0; wb_we = 0;
    ex_is_load_in = 0; ex_result = 0; mem_result = 0; wb_result = 0;
  endtask
  task automatic set_port(input int p, input logic [3:0] src, input logic used, input logic [31:0] rf);
    id_src_reg[p*4 +: 4] = src;
    id_src_used[p] = used;
    id_rf_data[p*32 +: 32] = rf;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic load_use_setup();
    idle();
    id_valid = 1; ex_is_load_in = 1; ex_we = 1; ex_dest_reg = 2;
    set_port(1, 2, 1, 32'h99);
  endtask
  task automatic test_reset();
    idle();
    load_use_setup();
    #2;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass++;
    total++; if (ex_valid !== 1'b0 || ex_dest_we !== 1'b0 || ex_is_load !== 1'b0) $display("FAIL reset_flags: got %b%b%b want 000", ex_valid, ex_dest_we, ex_is_load); else pass++;
    total++; if (ex_operand !== '0 || ex_ctrl !== '0 || ex_dest !== '0) $display("FAIL reset_data: got %h/%h/%h want 0", ex_operand, ex_ctrl, ex_dest); else pass++;
    total++; if (stall_count !== '0) $display("FAIL reset_count: got %0d want 0", stall_count); else pass++;
    idle();
    @(posedge clk); #1 reset = 1;
  endtask
  task automatic test_ex_forward();
    idle();
    id_valid = 1; id_ctrl = 16'h1234; id_dest_reg = 4'd6; id_dest_we = 1;
    ex_we = 1; ex_dest_reg = 3; ex_result = 32'hAAAA0001;
    set_port(0, 3, 1, 32'h11);
    sb.push_back('{1'b1, 32'hAAAA0001, 0});
    #1;
    total++; if (stall !== 1'b0) $display("FAIL ex_fwd_stall: got %b want 0", stall); else pass++;
    tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.v || ex_operand[e.port*32 +: 32] !== e.op) $display("FAIL ex_fwd_op: got %b/%h want %b/%h", ex_valid, ex_operand[e.port*32 +: 32], e.v, e.op); else pass++;
    total++; if (ex_ctrl !== 16'h1234 || ex_dest !== 4'd6 || ex_dest_we !== 1'b1) $display("FAIL ex_fwd_ctrl: got %h/%h/%b want 1234/6/1", ex_ctrl, ex_dest, ex_dest_we); else pass++;
  endtask
  task automatic test_priority();
    idle();
    id_valid = 1;
    set_port(2, 5, 1, 32'hF0);
    ex_dest_reg = 5; mem_dest_reg = 5; wb_dest_reg = 5;
    ex_result = 1; mem_result = 2; wb_result = 3;
    for (int k = 0; k < 3; k++) begin
      ex_we = (k < 1); mem_we = (k < 2); wb_we = 1;
      sb.push_back('{1'b1, 32'(k + 1), 2});
      tick();
      e = sb.pop_front();
      total++; if (ex_valid !== e.v || ex_operand[e.port*32 +: 32] !== e.op) $display("FAIL priority_%0d: got %h want %h", k, ex_operand[e.port*32 +: 32], e.op); else pass++;
    end
  endtask
  task automatic test_load_use();
    load_use_setup();
    id_dest_we = 1; id_is_load = 1;
    sb.push_back('{1'b0, 32'h0, 1});
    #1;
    total++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else pass++;
    tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.v || ex_dest_we !== 1'b0 || ex_is_load !== 1'b0 || ex_ctrl !== '0) $display("FAIL lu_bubble: got %b%b%b/%h want 000/0", ex_valid, ex_dest_we, ex_is_load, ex_ctrl); else pass++;
    total++; if (stall_count !== 16'd1) $display("FAIL lu_count: got %0d want 1", stall_count); else pass++;
    ex_is_load_in = 0; ex_we = 0; mem_we = 1; mem_dest_reg = 2; mem_result = 32'h55;
    sb.push_back('{1'b1, 32'h55, 1});
    #1;
    total++; if (stall !== 1'b0) $display("FAIL lu_release: got %b want 0", stall); else pass++;
    tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.v || ex_operand[e.port*32 +: 32] !== e.op) $display("FAIL lu_mem_fwd: got %b/%h want %b/%h", ex_valid, ex_operand[e.port*32 +: 32], e.v, e.op); else pass++;
    total++; if (stall_count !== 16'd1 || ex_is_load !== 1'b1) $display("FAIL lu_after: got %0d/%b want 1/1", stall_count, ex_is_load); else pass++;
  endtask
  task automatic test_unused_pc();
    for (int k = 0; k < 2; k++) begin
      load_use_setup();
      if (k == 0) set_port(1, 2, 0, 32'h77);
      else begin ex_dest_reg = 15; set_port(1, 15, 1, 32'h88); end
      sb.push_back('{1'b1, (k == 0) ? 32'h77 : 32'h88, 1});
      #1;
      total++; if (stall !== 1'b0) $display("FAIL unused_pc_stall_%0d: got %b want 0", k, stall); else pass++;
      tick();
      e = sb.pop_front();
      total++; if (ex_valid !== e.v || ex_operand[e.port*32 +: 32] !== e.op) $display("FAIL unused_pc_op_%0d: got %h want %h", k, ex_operand[e.port*32 +: 32], e.op); else pass++;
    end
  endtask
  task automatic test_multi_port();
    idle();
    id_valid = 1; mem_we = 1; mem_dest_reg = 7; mem_result = 32'hC0DE;
    for (int p = 0; p < 3; p++) begin
      set_port(p, 7, 1, 32'(p));
      sb.push_back('{1'b1, 32'hC0DE, p});
    end
    tick();
    for (int p = 0; p < 3; p++) begin
      e = sb.pop_front();
      total++; if (ex_operand[e.port*32 +: 32] !== e.op) $display("FAIL multi_port_%0d: got %h want %h", p, ex_operand[e.port*32 +: 32], e.op); else pass++;
    end
  endtask
  task automatic test_flush();
    logic [15:0] c0;
    c0 = stall_count;
    load_use_setup();
    flush = 1; id_ctrl = 16'hBEEF; id_dest_we = 1;
    sb.push_back('{1'b0, 32'h0, 0});
    #1;
    total++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else pass++;
    tick();
    e = sb.pop_front();
    total++; if (ex_valid !== e.v || ex_ctrl !== '0 || ex_dest_we !== 1'b0) $display("FAIL flush_bubble: got %b/%h/%b want 0/0/0", ex_valid, ex_ctrl, ex_dest_we); else pass++;
    total++; if (stall_count !== c0) $display("FAIL flush_count: got %0d want %0d", stall_count, c0); else pass++;
    idle();
    id_dest_we = 1; id_is_load = 1;
    tick();
    total++; if (ex_valid !== 1'b0 || ex_dest_we !== 1'b0 || ex_is_load !== 1'b0) $display("FAIL invalid_gate: got %b%b%b want 000", ex_valid, ex_dest_we, ex_is_load); else pass++;
  endtask
  task automatic test_reset_mid();
    idle();
    id_valid = 1; id_ctrl = 16'h00A5; set_port(0, 1, 1, 32'h1357);
    tick();
    load_use_setup();
    tick();
    total++; if (stall !== 1'b1 || stall_count === '0) $display("FAIL mid_pre: got %b/%0d want 1/nonzero", stall, stall_count); else pass++;
    #2 reset = 0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", stall); else pass++;
    total++; if (ex_valid !== 0 || ex_operand !== '0 || ex_ctrl !== '0 || ex_dest !== '0 || ex_dest_we !== 0 || ex_is_load !== 0) $display("FAIL mid_outputs: got %b/%h/%h want all 0", ex_valid, ex_operand, ex_ctrl); else pass++;
    total++; if (stall_count !== '0 || stall_count2 !== '0) $display("FAIL mid_count: got %0d/%0d want 0/0", stall_count, stall_count2); else pass++;
    @(posedge clk); #1 reset = 1;
  endtask
  task automatic test_saturation();
    logic [1:0] want;
    load_use_setup();
    for (int k = 1; k <= 5; k++) begin
      want = (k > 3) ? 2'd3 : 2'(k);
      tick();
      total++; if (stall_count2 !== want) $display("FAIL sat_%0d: got %0d want %0d", k, stall_count2, want); else pass++;
    end
    total++; if (stall_count !== 16'd5) $display("FAIL sat_wide: got %0d want 5", stall_count); else pass++;
    idle();
  endtask
  initial begin
    test_reset();
    test_ex_forward();
    test_priority();
    test_load_use();
    test_unused_pc();
    test_multi_port();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/id_ex_forward_stage.md
Name: id_ex_forward_stage

Overview:
- Parametrised successor to the decode-stage operand path: N-port operand forwarding, load-use interlock, branch flush and a registered ID/EX pipeline boundary with a valid bit.
- Sits between register-file read (ID) and EX; drives the IF/ID stall and supplies EX with resolved operands and the control word.
- Adds a saturating stall-cycle performance counter.

Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 4, register address width
- NUM_PORTS, 3, read ports resolved per instruction (A, B, D)
- CTRL_W, 16, opaque packed decode-control width, registered unchanged
- PC_REG, 15, register index never forwarded or interlocked (RF supplies PC value)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src_reg  in  NUM_PORTS*REG_AW  source register per port, port i at [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_PORTS  port i is actually read by the instruction
- id_rf_data  in  NUM_PORTS*DATA_W  register-file read data per port
- id_ctrl  in  CTRL_W  decode control word
- id_dest_reg  in  REG_AW  ID destination
- id_dest_we  in  1  ID writes RF
- id_is_load  in  1  ID is a load
- ex_dest_reg, mem_dest_reg, wb_dest_reg  in  REG_AW each  downstream destinations
- ex_we, mem_we, wb_we  in  1 each  downstream RF write enables
- ex_is_load_in  in  1  instruction now in EX is a load
- ex_result, mem_result, wb_result  in  DATA_W each  forwarding data
- flush  in  1  branch taken, discard ID
- stall  out  1  hold PC and IF/ID
- ex_valid  out  1  registered valid
- ex_operand  out  NUM_PORTS*DATA_W  registered resolved operands
- ex_ctrl  out  CTRL_W  registered control
- ex_dest  out  REG_AW  registered destination
- ex_dest_we  out  1  registered write enable
- ex_is_load  out  1  registered load flag
- stall_count  out  CNT_W  saturating stall-cycle count

Behaviour:
- Reset (reset=0, asynchronous): ex_valid, ex_operand, ex_ctrl, ex_dest, ex_dest_we, ex_is_load and stall_count all 0. stall is combinational; it is 0 while reset is asserted.
- Forward select per port i (combinational). If id_src_used[i]=0 or src==PC_REG, select id_rf_data. Otherwise use the first match in priority order:
  - EX: ex_we & src==ex_dest_reg & !ex_is_load_in → ex_result
  - MEM: mem_we & src==mem_dest_reg → mem_result
  - WB: wb_we & src==wb_dest_reg → wb_result
  - else id_rf_data
- Load-use hazard: id_valid & ex_is_load_in & ex_we & any port i with used, src!=PC_REG and src==ex_dest_reg.
- stall = hazard & !flush.
- Rising edge, priority order:
  1. flush=1 → bubble (ex_valid, ex_dest_we, ex_is_load = 0; ex_ctrl = 0; ex_operand and ex_dest hold).
  2. stall=1 → bubble, same as flush.
  3. Otherwise → load ex_valid=id_valid, operands, ctrl, dest, and the we/load flags gated by id_valid.
- id_valid=0 without a stall or flush also yields a bubble via the gating in case 3.
- Load-use costs exactly 1 stall cycle. On the next cycle the load is in MEM and forwards via mem_result.
- stall_count increments when stall=1 and saturates at all-ones (no wrap).
- Flush in the same cycle as a hazard: flush wins, stall=0, stall_count does not increment.
- Multiple ports naming the same register each resolve independently and identically.
- Reset mid-stall: outputs clear immediately; stall drops once reset asserts.

Test Plan:
- EX forwarding: ex_we=1, ex_dest_reg=3, ex_result=0xAAAA0001, port0 src=3 used, rf=0x11 → next edge ex_operand[0]=0xAAAA0001, stall=0.
- Priority: EX, MEM and WB all target r5 with results 1, 2, 3 → operand=1. Clear ex_we → 2. Also clear mem_we → 3.
- Load-use: ex_is_load_in=1, ex_we=1, ex_dest_reg=2, port1 src=2 used, id_valid=1 → stall=1 for one cycle, ex_valid=0 on that edge, stall_count=1. Next cycle load in MEM, mem_result=0x55 → ex_operand[1]=0x55, ex_valid=1.
- Unused/PC port: same load-use setup but id_src_used[1]=0, or src=15 → stall=0, operand=id_rf_data.
- Flush + hazard same cycle: stall=0, ex_valid=0 next edge, stall_count unchanged. Reset asserted mid-sequence → all outputs 0 asynchronously.
- Counter saturation with CNT_W=2: 5 consecutive stall cycles → stall_count reads 1, 2, 3, 3, 3.
